// File: rtl/host_sequencer.sv
// Host-side sequencer: streams a load block into data memory, kicks the core,
// waits for END (with timeout), then streams the result block back out.
module host_sequencer #(
    parameter int          LOAD_WORDS   = 8,
    parameter logic [15:0] LOAD_BASE    = 16'h0000,
    parameter logic [15:0] RESULT_BASE  = 16'h0040,
    parameter int          RESULT_WORDS = 4,
    parameter int          TIMEOUT      = 4096
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        go,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [15:0] mem_rdata,
    output logic        START,
    input  logic        END,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        timeout_err
);

    localparam int LW = $clog2(LOAD_WORDS + 1);
    localparam int RW = $clog2(RESULT_WORDS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_KICK,
        S_WAIT,
        S_RD_ISSUE,
        S_RD_CAPT,
        S_PRESENT,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state, state_nx;
    logic [LW-1:0] lcnt, lcnt_nx;
    logic [RW-1:0] rcnt, rcnt_nx;
    logic [TW-1:0] tmr, tmr_nx;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state    <= S_IDLE;
            lcnt     <= '0;
            rcnt     <= '0;
            tmr      <= '0;
            out_data <= 16'h0000;
        end else begin
            state <= state_nx;
            lcnt  <= lcnt_nx;
            rcnt  <= rcnt_nx;
            tmr   <= tmr_nx;
            // Read data arrives one cycle after mem_re, i.e. while in RD_CAPT
            if (state == S_RD_CAPT)
                out_data <= mem_rdata;
        end
    end

    always_comb begin
        state_nx    = state;
        lcnt_nx     = lcnt;
        rcnt_nx     = rcnt;
        tmr_nx      = tmr;
        in_ready    = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_addr    = 16'h0000;
        mem_wdata   = 16'h0000;
        START       = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        timeout_err = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (go) begin
                    state_nx = S_LOAD;
                    lcnt_nx  = '0;
                end
            end
            S_LOAD: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                // The write is issued in the same cycle as the stream handshake
                if (in_valid) begin
                    mem_we    = 1'b1;
                    mem_addr  = LOAD_BASE + 16'(lcnt);
                    mem_wdata = in_data;
                    lcnt_nx   = lcnt + LW'(1);
                    if (lcnt == LW'(LOAD_WORDS - 1))
                        state_nx = S_KICK;
                end
            end
            S_KICK: begin
                busy     = 1'b1;
                START    = 1'b1;
                tmr_nx   = '0;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (END) begin
                    state_nx = S_RD_ISSUE;
                    rcnt_nx  = '0;
                end else if (tmr == TW'(TIMEOUT - 1)) begin
                    state_nx = S_ERR;
                end else begin
                    tmr_nx = tmr + TW'(1);
                end
            end
            S_RD_ISSUE: begin
                busy     = 1'b1;
                mem_re   = 1'b1;
                mem_addr = RESULT_BASE + 16'(rcnt);
                state_nx = S_RD_CAPT;
            end
            S_RD_CAPT: begin
                busy     = 1'b1;
                state_nx = S_PRESENT;
            end
            S_PRESENT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    rcnt_nx  = rcnt + RW'(1);
                    state_nx = (rcnt == RW'(RESULT_WORDS - 1)) ? S_DONE : S_RD_ISSUE;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            S_ERR: begin
                // Error is sticky until the host retries with go
                timeout_err = 1'b1;
                if (go) begin
                    state_nx = S_LOAD;
                    lcnt_nx  = '0;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_host_sequencer.sv
// Bench for host_sequencer: table of nominal runs plus hand-written timeout and
// mid-run reset sequences; writes and result words are checked via queues.
module tb_host_sequencer;

    logic        clk = 1'b0;
    logic        RESET, go, in_valid, in_ready, mem_we, mem_re, START, END;
    logic        out_valid, out_ready, busy, done, timeout_err;
    logic [15:0] in_data, mem_addr, mem_wdata, mem_rdata, out_data;

    int checks = 0, failures = 0, cyc = 0;
    int wr_cnt = 0, re_cnt = 0, start_cnt = 0, done_cnt = 0, out_cnt = 0;
    int last_wr_cyc = 0, start_cyc = 0;

    logic [31:0] wr_q[$];
    logic [15:0] out_q[$];
    logic [15:0] ldmem[0:255];
    logic [15:0] res[0:1];
    logic [31:0] e_wr;
    logic [15:0] e_out;

    typedef struct {
        string       name;
        logic [3:0]  pat;
        logic [15:0] base;
        int          end_dly;
        int          stall;
        bit          spur;
        logic [15:0] r0, r1;
        int          exp_writes;
        int          exp_gap;
        int          exp_outs;
    } vec_t;
    vec_t tbl[5];

    host_sequencer #(
        .LOAD_WORDS(4), .LOAD_BASE(16'h0000), .RESULT_BASE(16'h0020),
        .RESULT_WORDS(2), .TIMEOUT(16)
    ) dut (
        .clk(clk), .RESET(RESET), .go(go),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .START(START), .END(END),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Data memory model: load region in ldmem, result words at 0x20/0x21
    always @(posedge clk) begin
        if (mem_we) ldmem[mem_addr[7:0]] <= mem_wdata;
        if (mem_re)
            mem_rdata <= (mem_addr == 16'h0020) ? res[0] :
                         (mem_addr == 16'h0021) ? res[1] : ldmem[mem_addr[7:0]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        chk("we_re_exclusive", 32'(mem_we & mem_re), 0);
        if (!mem_we && !mem_re) chk("addr_zero_idle", 32'(mem_addr), 0);
        if (mem_we) begin
            chk("write_needs_valid", 32'(in_valid), 1);
            if (wr_q.size() == 0) chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
            else begin
                e_wr = wr_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e_wr[31:16]));
                chk("wr_data", 32'(mem_wdata), 32'(e_wr[15:0]));
            end
            wr_cnt++;
            last_wr_cyc = cyc;
        end
        if (mem_re) re_cnt++;
        if (START) begin start_cnt++; start_cyc = cyc; end
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
            if (out_q.size() == 0) chk("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
            else begin
                e_out = out_q.pop_front();
                chk("out_data", 32'(out_data), 32'(e_out));
            end
            out_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic reset_vals(input string p);
        chk({p, "_busy"}, 32'(busy), 0);
        chk({p, "_in_ready"}, 32'(in_ready), 0);
        chk({p, "_start"}, 32'(START), 0);
        chk({p, "_we_re"}, 32'({mem_we, mem_re}), 0);
        chk({p, "_out_valid"}, 32'(out_valid), 0);
        chk({p, "_done_err"}, 32'({done, timeout_err}), 0);
        chk({p, "_out_data"}, 32'(out_data), 0);
        chk({p, "_wdata_addr"}, {mem_wdata, mem_addr}, 0);
    endtask

    task automatic feed(input logic [3:0] pat, input logic [15:0] base, input bit spur);
        int k = 0, slot = 0, pushed = -1;
        while (k < 4 && slot < 40) begin
            in_valid = pat[slot % 4];
            in_data  = base + 16'(k);
            if (in_valid && pushed != k) begin
                wr_q.push_back({16'(k), base + 16'(k)});
                pushed = k;
            end
            go  = spur;
            END = spur;
            @(negedge clk);
            if (in_valid && in_ready) k++;
            slot++;
            tick();
        end
        in_valid = 1'b0; go = 1'b0; END = 1'b0;
        chk("feed_complete", k, 4);
    endtask

    task automatic wait_start(output int kcyc);
        bit ok = 0;
        kcyc = 0;
        for (int i = 0; i < 40; i++) begin
            if (START) begin ok = 1; kcyc = cyc; break; end
            @(negedge clk);
        end
        chk("start_seen", 32'(ok), 1);
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("done_seen", 32'(ok), 1);
    endtask

    task automatic readback(input int stall);
        logic [15:0] d0;
        int n;
        out_ready = (stall == 0);
        for (int r = 0; r < 2; r++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!out_valid && n < 60);
            chk("out_valid_seen", 32'(out_valid), 1);
            if (!out_valid) return;
            d0 = out_data;
            if (stall > 0) begin
                for (int s = 0; s < stall; s++) begin
                    chk("bp_valid_held", 32'(out_valid), 1);
                    chk("bp_data_stable", 32'(out_data), 32'(d0));
                    chk("bp_no_read", 32'(mem_re), 0);
                    @(negedge clk);
                end
                tick(); out_ready = 1'b1;
                @(negedge clk);
                tick(); out_ready = 1'b0;
            end
        end
    endtask

    task automatic finish_run(input int dly, input int stall, input logic [15:0] r0, input logic [15:0] r1);
        int kc;
        res[0] = r0; res[1] = r1;
        out_q.push_back(r0); out_q.push_back(r1);
        wait_start(kc);
        if (dly == 0) END = 1'b1;
        else begin repeat (dly) tick(); END = 1'b1; end
        readback(stall);
        wait_done();
        END = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        int w0, s0, d0, o0, r0c, kc, n;
        tbl[0] = '{"nominal",  4'b1111, 16'h0001, 5, 0, 1'b0, 16'hAAAA, 16'h5555, 4, 1, 2};
        tbl[1] = '{"in_stall", 4'b0101, 16'h1230, 5, 0, 1'b0, 16'h1234, 16'h8765, 4, 1, 2};
        tbl[2] = '{"out_bp",   4'b1111, 16'h4400, 3, 7, 1'b0, 16'hBEEF, 16'hCAFE, 4, 1, 2};
        tbl[3] = '{"spurious", 4'b1111, 16'h0001, 5, 0, 1'b1, 16'hAAAA, 16'h5555, 4, 1, 2};
        tbl[4] = '{"end_kick", 4'b1011, 16'h9000, 0, 2, 1'b0, 16'h0F0F, 16'hF0F0, 4, 1, 2};

        RESET = 1'b1; go = 1'b0; in_valid = 1'b0; in_data = 16'h0; END = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_vals("por");
        RESET = 1'b0;
        repeat (5) tick();
        chk("idle_no_access", wr_cnt + re_cnt + start_cnt, 0);
        chk("idle_busy", 32'(busy), 0);

        for (int i = 0; i < 5; i++) begin
            w0 = wr_cnt; s0 = start_cnt; d0 = done_cnt; o0 = out_cnt;
            go = 1'b1; tick(); go = 1'b0;
            feed(tbl[i].pat, tbl[i].base, tbl[i].spur);
            finish_run(tbl[i].end_dly, tbl[i].stall, tbl[i].r0, tbl[i].r1);
            chk({tbl[i].name, "_writes"}, wr_cnt - w0, tbl[i].exp_writes);
            chk({tbl[i].name, "_start_pulses"}, start_cnt - s0, 1);
            chk({tbl[i].name, "_start_gap"}, start_cyc - last_wr_cyc, tbl[i].exp_gap);
            chk({tbl[i].name, "_done_pulses"}, done_cnt - d0, 1);
            chk({tbl[i].name, "_outs"}, out_cnt - o0, tbl[i].exp_outs);
            chk({tbl[i].name, "_idle_busy"}, 32'(busy), 0);
            chk({tbl[i].name, "_queues_empty"}, wr_q.size() + out_q.size(), 0);
        end

        // Timeout: END never arrives
        r0c = re_cnt; d0 = done_cnt;
        go = 1'b1; tick(); go = 1'b0;
        feed(4'b1111, 16'h0100, 1'b0);
        wait_start(kc);
        n = 0;
        while (!timeout_err && n < 40) begin @(negedge clk); n++; end
        chk("timeout_reached", 32'(timeout_err), 1);
        chk("timeout_cycle", cyc - kc, 17);
        chk("err_busy", 32'(busy), 0);
        repeat (3) tick();
        chk("err_sticky", 32'(timeout_err), 1);
        chk("err_no_readback", re_cnt - r0c, 0);
        chk("err_no_done", done_cnt - d0, 0);
        go = 1'b1; tick(); go = 1'b0;
        chk("err_cleared", 32'(timeout_err), 0);
        chk("restart_busy", 32'(busy), 1);
        feed(4'b1111, 16'h0200, 1'b0);
        finish_run(2, 0, 16'h1111, 16'h2222);
        chk("restart_queues_empty", wr_q.size() + out_q.size(), 0);

        // Reset in WAIT, then END after release must do nothing
        go = 1'b1; tick(); go = 1'b0;
        feed(4'b1111, 16'h0300, 1'b0);
        wait_start(kc);
        tick(); tick();
        chk("pre_reset_busy", 32'(busy), 1);
        r0c = re_cnt; s0 = start_cnt;
        RESET = 1'b1; #1;
        reset_vals("async_rst");
        tick(); tick();
        RESET = 1'b0; tick();
        END = 1'b1; repeat (3) tick(); END = 1'b0;
        repeat (5) tick();
        chk("rst_no_readback", re_cnt - r0c, 0);
        chk("rst_no_start", start_cnt - s0, 0);
        reset_vals("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/host_sequencer.md
HOST_SEQUENCER -- requirements
Module: host_sequencer

Interface
REQ-001 Parameter LOAD_WORDS, default 8: number of words written to data memory before a run.
REQ-002 Parameter LOAD_BASE, default 16'h0000: first data-memory address of the load region.
REQ-003 Parameter RESULT_BASE, default 16'h0040: first data-memory address of the result region.
REQ-004 Parameter RESULT_WORDS, default 4: number of result words streamed out after a run.
REQ-005 Parameter TIMEOUT, default 4096: maximum number of WAIT cycles before END is declared missing.
REQ-006 clk  in  1  single clock; all state changes on the rising edge.
REQ-007 RESET  in  1  asynchronous, active-high reset.
REQ-008 go  in  1  request to start a load/run/readback sequence; sampled in IDLE and ERR only.
REQ-009 in_valid / in_data[15:0] / in_ready  in/in/out  1/16/1  load-word stream; a transfer occurs when valid and ready are both high.
REQ-010 mem_addr[15:0] / mem_wdata[15:0] / mem_we / mem_re  out  16/16/1/1  data-memory port.
REQ-011 mem_rdata[15:0]  in  16  read data, valid exactly one cycle after mem_re.
REQ-012 START  out  1  run pulse to the processor core.
REQ-013 END  in  1  run-complete level from the processor core.
REQ-014 out_valid / out_data[15:0] / out_ready  out/out/in  1/16/1  result-word stream; a transfer occurs when valid and ready are both high.
REQ-015 busy / done / timeout_err  out  1  status: sequence in progress / one-cycle completion pulse / sticky END timeout.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, KICK, WAIT, RD_ISSUE, RD_CAPT, PRESENT, DONE and ERR.
REQ-017 IDLE: busy=0 and all strobes low; go=1 -> LOAD with load counter lcnt=0.
REQ-018 LOAD: in_ready=1 and busy=1; on each in-stream transfer, in that same cycle, mem_we=1, mem_addr=LOAD_BASE+lcnt and mem_wdata=in_data (all combinational), then lcnt increments.
REQ-019 LOAD: the transfer that makes lcnt reach LOAD_WORDS -> KICK; in_ready SHALL be 0 in every other state.
REQ-020 KICK: START=1 for exactly one cycle, the WAIT timer clears, -> WAIT.
REQ-021 WAIT: END=1 -> RD_ISSUE with read counter rcnt=0; otherwise the timer increments, and at TIMEOUT cycles without END -> ERR.
REQ-022 END SHALL be ignored in every state except WAIT, including END already high during KICK (it is acted on in the first WAIT cycle).
REQ-023 RD_ISSUE: mem_re=1 and mem_addr=RESULT_BASE+rcnt for one cycle, -> RD_CAPT.
REQ-024 RD_CAPT: mem_rdata is registered into out_data, -> PRESENT.
REQ-025 PRESENT: out_valid=1 and out_data is held stable until the out-stream transfer; on the transfer rcnt increments, then -> RD_ISSUE if rcnt<RESULT_WORDS, otherwise -> DONE.
REQ-026 DONE: done=1 for one cycle, busy=0, -> IDLE.
REQ-027 ERR: timeout_err=1 and busy=0; go=1 clears timeout_err and -> LOAD with lcnt=0.
REQ-028 go in any state other than IDLE or ERR SHALL be ignored.
REQ-029 busy SHALL be 1 in LOAD through PRESENT inclusive.
REQ-030 mem_we and mem_re SHALL never be high in the same cycle; mem_addr SHALL be 0 when both are low.
REQ-031 Address arithmetic is 16-bit and wraps modulo 2^16.
REQ-032 The counters SHALL be wide enough for LOAD_WORDS, RESULT_WORDS and TIMEOUT without overflow.

Reset
REQ-033 RESET=1, at any time including mid-LOAD or mid-WAIT, SHALL immediately force IDLE.
REQ-034 On reset, all counters clear and START, mem_we, mem_re, in_ready, out_valid, busy, done and timeout_err are 0; out_data and mem_wdata are 16'h0000.
REQ-035 After RESET deasserts, no memory access or START pulse SHALL occur until go is sampled.

Verification (LOAD_WORDS=4, RESULT_WORDS=2, TIMEOUT=16, LOAD_BASE=0, RESULT_BASE=16'h0020)
REQ-036 Nominal run: go, words 1,2,3,4 with in_valid always high, END raised 5 cycles after START, memory 0x20=16'hAAAA and 0x21=16'h5555, out_ready=1 -> writes land at addresses 0..3 on 4 consecutive cycles; START is a single pulse the cycle after the 4th write; out stream delivers AAAA then 5555; done pulses once.
REQ-037 Input stalls: in_valid toggling 1,0,1,0 -> exactly 4 writes with contiguous addresses and no write in a cycle where in_valid=0.
REQ-038 Output backpressure: out_ready held 0 for 7 cycles in PRESENT -> out_valid stays 1 with out_data constant, and no second mem_re is issued until the transfer.
REQ-039 Timeout: END never raised -> ERR entered 16 cycles after WAIT is entered; timeout_err=1 and busy=0; a later go clears timeout_err and restarts LOAD at address 0.
REQ-040 Reset mid-operation: RESET asserted in WAIT, then END pulsed after release -> no state change, no readback, all outputs at reset values.
REQ-041 Spurious inputs: go asserted during LOAD, and END asserted during LOAD -> both ignored; word count and START timing are unchanged from the nominal run.
